// File: rtl/mmio_io_controller.sv
// MMIO board-I/O peripheral: LED register, synchronized/debounced switches, sticky change flags.
// Define IO_CYCLE_COUNTER_EN to add the free-running 64-bit cycle counter at offset 0x18.
module mmio_io_controller #(
  parameter logic [63:0] IO_BASE         = 64'h0000_0000_0000_1000,
  parameter int          DEBOUNCE_CYCLES = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] address,
  input  logic [63:0] write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [63:0] read_data,
  output logic        hit,
  input  logic [17:0] switches,
  output logic [26:0] leds
);

  localparam int               NUM_SW   = 18;
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] SEL_LED = 2'd0;
  localparam logic [1:0] SEL_SW  = 2'd1;
  localparam logic [1:0] SEL_CHG = 2'd2;
  localparam logic [1:0] SEL_CNT = 2'd3;

  logic [26:0]       r_leds;
  logic [NUM_SW-1:0] r_sync1;
  logic [NUM_SW-1:0] r_sync2;
  logic [NUM_SW-1:0] r_deb;
  logic [NUM_SW-1:0] r_chg;
  logic [CNT_W-1:0]  r_cnt [NUM_SW];

  logic              w_inWindow;
  logic [1:0]        w_sel;
  logic              w_mapped;
  logic              w_wrEn;
  logic [NUM_SW-1:0] w_accept;
  logic [NUM_SW-1:0] w_clear;
  logic              w_unused;

  assign w_inWindow = (address[63:5] == IO_BASE[63:5]);
  assign w_sel      = address[4:3];

`ifdef IO_CYCLE_COUNTER_EN
  logic [63:0] r_cycles;
  assign w_mapped = 1'b1;
`else
  assign w_mapped = (w_sel != SEL_CNT);
`endif

  // hit qualifies loads only: idle and store-only cycles report no hit
  assign hit    = MemRead && w_inWindow && w_mapped;
  assign w_wrEn = MemWrite && w_inWindow && w_mapped;
  assign leds   = r_leds;

  // Sub-word address bits and the upper store-data bits have no destination
  assign w_unused = ^{address[2:0], write_data[63:27]};

  always_comb begin
    w_accept = '0;
    w_clear  = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      w_accept[i] = (r_sync2[i] != r_deb[i]) && (r_cnt[i] == CNT_LAST);
    end
    if (w_wrEn && (w_sel == SEL_CHG)) begin
      w_clear = write_data[NUM_SW-1:0];
    end
  end

  // Synchronizer, per-switch debounce counters and sticky flags (a new change beats a W1C)
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_chg   <= '0;
      for (int i = 0; i < NUM_SW; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= switches;
      r_sync2 <= r_sync1;
      r_deb   <= r_deb ^ w_accept;
      r_chg   <= (r_chg & ~w_clear) | w_accept;
      for (int i = 0; i < NUM_SW; i++) begin
        if ((r_sync2[i] == r_deb[i]) || w_accept[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_leds <= '0;
    end else if (w_wrEn && (w_sel == SEL_LED)) begin
      r_leds <= write_data[26:0];
    end
  end

`ifdef IO_CYCLE_COUNTER_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cycles <= '0;
    end else begin
      r_cycles <= r_cycles + 64'd1;
    end
  end
`endif

  // Loads see pre-edge state, so a combined load+store returns the old value
  always_comb begin
    read_data = '0;
    if (hit) begin
      case (w_sel)
        SEL_LED: read_data = {37'd0, r_leds};
        SEL_SW:  read_data = {46'd0, r_deb};
        SEL_CHG: read_data = {46'd0, r_chg};
        default: begin
`ifdef IO_CYCLE_COUNTER_EN
          read_data = r_cycles;
`else
          read_data = '0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_io_controller.sv
// Self-checking bench for mmio_io_controller: directed vector table, multi-cycle
// debounce/W1C/reset sequences, and randomized traffic against a behavioural model.
module tb_mmio_io_controller;

  localparam logic [63:0] BASE = 64'h1000;
  localparam int          DEB  = 4;
`ifdef IO_CYCLE_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [63:0] address;
  logic [63:0] write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [63:0] read_data;
  logic        hit;
  logic [17:0] switches;
  logic [26:0] leds;

  int checks   = 0;
  int failures = 0;

  mmio_io_controller #(
    .IO_BASE(BASE),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .address(address),
    .write_data(write_data),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .read_data(read_data),
    .hit(hit),
    .switches(switches),
    .leds(leds)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Behavioural model: a switch change is accepted once the last DEB synchronized
  // samples all disagree with the debounced value; synchronized = raw from two edges ago.
  logic [17:0] mDeb;
  logic [17:0] mChg;
  logic [26:0] mLeds;
  logic [63:0] mCnt;
  logic [17:0] rawQ[$];
  logic [17:0] s2Q[$];

  always @(posedge clock) begin : modelBlk
    logic [17:0] s2;
    logic [17:0] acc;
    logic [17:0] clr;
    if (reset) begin
      mDeb  = '0;
      mChg  = '0;
      mLeds = '0;
      mCnt  = '0;
      rawQ.delete();
      s2Q.delete();
    end else begin
      s2 = (rawQ.size() >= 2) ? rawQ[rawQ.size()-2] : 18'd0;
      rawQ.push_back(switches);
      if (rawQ.size() > 4) void'(rawQ.pop_front());
      s2Q.push_back(s2);
      if (s2Q.size() > DEB) void'(s2Q.pop_front());
      acc = '0;
      if (s2Q.size() == DEB) begin
        for (int i = 0; i < 18; i++) begin
          bit allDiffer;
          allDiffer = 1'b1;
          foreach (s2Q[j]) if (s2Q[j][i] == mDeb[i]) allDiffer = 1'b0;
          acc[i] = allDiffer;
        end
      end
      mDeb = mDeb ^ acc;
      clr  = '0;
      if (MemWrite && (address[63:5] == BASE[63:5])) begin
        if (address[4:3] == 2'd0) mLeds = write_data[26:0];
        if (address[4:3] == 2'd2) clr = write_data[17:0];
      end
      mChg = (mChg & ~clr) | acc;
      mCnt = mCnt + 64'd1;
    end
  end

  function automatic logic modelHit(input logic [63:0] a, input logic rd);
    return rd && (a[63:5] == BASE[63:5]) && ((a[4:3] != 2'd3) || CNT_EN);
  endfunction

  function automatic logic [63:0] modelRead(input logic [63:0] a, input logic rd);
    if (!modelHit(a, rd)) return 64'd0;
    case (a[4:3])
      2'd0:    return {37'd0, mLeds};
      2'd1:    return {46'd0, mDeb};
      2'd2:    return {46'd0, mChg};
      default: return mCnt;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] d,
                               input logic rd, input logic wr);
    address    = a;
    write_data = d;
    MemRead    = rd;
    MemWrite   = wr;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic loadCheck(input string name, input logic [63:0] a,
                           input logic [63:0] expRd, input logic expHit);
    applyStimulus(a, 64'd0, 1'b1, 1'b0);
    #1;
    checkOutput({name, "_data"}, read_data, expRd);
    checkOutput({name, "_hit"}, {63'd0, hit}, {63'd0, expHit});
    applyStimulus(64'd0, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic storeOp(input logic [63:0] a, input logic [63:0] d);
    applyStimulus(a, d, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(64'd0, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    reset    = 1'b1;
    switches = '0;
    applyStimulus(64'd0, 64'd0, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        rd;
    logic        wr;
    logic [63:0] expRd;
    logic        expHit;
    logic [26:0] expLeds;
  } vec_t;

  vec_t vecs[14];

  logic [17:0] rawSw;
  logic [63:0] rAddr;

  initial begin
    reset    = 1'b1;
    switches = '0;
    applyStimulus(64'd0, 64'd0, 1'b0, 1'b0);

    // expLeds is the LED value before the row's own edge
    vecs[0]  = '{64'h1000, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 27'h0};
    vecs[1]  = '{64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 64'h0, 1'b0, 27'h0};
    vecs[2]  = '{64'h1000, 64'h0, 1'b1, 1'b0, 64'h7FF_FFFF, 1'b1, 27'h7FF_FFFF};
    vecs[3]  = '{64'h1008, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 64'h0, 1'b0, 27'h7FF_FFFF};
    vecs[4]  = '{64'h1008, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 27'h7FF_FFFF};
    vecs[5]  = '{64'h2000, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 27'h7FF_FFFF};
    vecs[6]  = '{64'h1000, 64'h5, 1'b1, 1'b1, 64'h7FF_FFFF, 1'b1, 27'h7FF_FFFF};
    vecs[7]  = '{64'h1007, 64'h0, 1'b1, 1'b0, 64'h5, 1'b1, 27'h5};
    vecs[8]  = '{64'h1010, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 64'h0, 1'b0, 27'h5};
    vecs[9]  = '{64'h1010, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 27'h5};
    vecs[10] = '{64'h1_0000_1000, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 27'h5};
    vecs[11] = '{64'h1020, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 27'h5};
    vecs[12] = '{64'h1018, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 64'h0, 1'b0, 27'h5};
    vecs[13] = '{64'h1000, 64'h0, 1'b1, 1'b0, 64'h5, 1'b1, 27'h5};

    $display("[TB] directed vector table");
    doReset();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].wr);
      #4;
      checkOutput($sformatf("vec%0d_data", i), read_data, vecs[i].expRd);
      checkOutput($sformatf("vec%0d_hit", i), {63'd0, hit}, {63'd0, vecs[i].expHit});
      checkOutput($sformatf("vec%0d_leds", i), {37'd0, leds}, {37'd0, vecs[i].expLeds});
      nextCycle();
    end
    applyStimulus(64'd0, 64'd0, 1'b0, 1'b0);

    $display("[TB] cycle counter / unmapped offset");
    doReset();
    repeat (10) nextCycle();
    loadCheck("cnt10", 64'h1018, CNT_EN ? 64'd10 : 64'd0, CNT_EN);

    $display("[TB] switch 3 debounce latency");
    switches = 18'h8;
    for (int e = 0; e <= 5; e++) begin
      nextCycle();
      loadCheck($sformatf("sw3_edge%0d", e), 64'h1008, (e == 5) ? 64'h8 : 64'h0, 1'b1);
    end
    loadCheck("chg3", 64'h1010, 64'h8, 1'b1);

    $display("[TB] switch 5 bounce then stable");
    switches = 18'h28;
    repeat (3) nextCycle();
    switches = 18'h08;
    repeat (8) nextCycle();
    loadCheck("bounce_sw", 64'h1008, 64'h8, 1'b1);
    loadCheck("bounce_chg", 64'h1010, 64'h8, 1'b1);
    switches = 18'h28;
    repeat (8) nextCycle();
    loadCheck("stable_sw", 64'h1008, 64'h28, 1'b1);
    loadCheck("stable_chg", 64'h1010, 64'h28, 1'b1);

    $display("[TB] W1C and set-wins");
    storeOp(64'h1010, 64'h8);
    loadCheck("w1c_bit3", 64'h1010, 64'h20, 1'b1);
    switches = 18'h08;
    nextCycle();
    storeOp(64'h1010, 64'h20);
    loadCheck("w1c_bit5", 64'h1010, 64'h0, 1'b1);
    repeat (3) nextCycle();
    loadCheck("pre_accept_sw", 64'h1008, 64'h28, 1'b1);
    storeOp(64'h1010, 64'h20);
    loadCheck("setwins_chg", 64'h1010, 64'h20, 1'b1);
    loadCheck("setwins_sw", 64'h1008, 64'h08, 1'b1);

    $display("[TB] reset mid-debounce");
    doReset();
    switches = 18'h1;
    repeat (4) nextCycle();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      nextCycle();
      loadCheck($sformatf("rst_sw_edge%0d", e), 64'h1008, (e == 6) ? 64'h1 : 64'h0, 1'b1);
    end
    loadCheck("rst_chg", 64'h1010, 64'h1, 1'b1);

    $display("[TB] randomized traffic against model");
    doReset();
    rawSw = '0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 4) == 0) rawSw[$urandom_range(0, 17)] ^= 1'b1;
      if ($urandom_range(0, 9) == 0) rawSw[$urandom_range(0, 3)] ^= 1'b1;
      switches = rawSw;
      reset = ($urandom_range(0, 149) == 0);
      rAddr = BASE | 64'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) rAddr = {$urandom, $urandom};
      applyStimulus(rAddr, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0));
      @(negedge clock);
      checkOutput($sformatf("rand%0d_data", c), read_data, modelRead(address, MemRead));
      checkOutput($sformatf("rand%0d_hit", c), {63'd0, hit}, {63'd0, modelHit(address, MemRead)});
      checkOutput($sformatf("rand%0d_leds", c), {37'd0, leds}, {37'd0, mLeds});
      nextCycle();
    end
    reset = 1'b0;
    applyStimulus(64'd0, 64'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_io_controller.md
# mmio_io_controller

Memory-mapped I/O peripheral on the data-memory side of the pipelined ARMv8 core. It takes the MEM-stage load/store (address, write data, MemRead, MemWrite) for its address window and owns the board I/O. Board I/O is a 27-bit LED register plus 18 synchronized, debounced switches with sticky change flags. An optional free-running 64-bit cycle counter can be compiled in. Read data feeds the same MEM/WB path as data-memory reads.

## Interface
Parameters:
- IO_BASE, 64'h0000_0000_0000_1000, base of the 32-byte register window; must be 32-byte aligned.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a switch change is accepted; legal range ≥2.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  64  MEM-stage ALU result used as the byte address.
- write_data  input  64  store data.
- MemRead  input  1  load strobe.
- MemWrite  input  1  store strobe.
- read_data  output  64  load data, combinational from registered state.
- hit  output  1  address decodes to a mapped register in this window.
- switches  input  18  raw asynchronous board switches.
- leds  output  27  LED register contents.

## Operation
- Decode: in-window when address[63:5] == IO_BASE[63:5]. address[4:3] selects the register; address[2:0] are ignored. All accesses are full 64-bit.
- Offset 0x00, LED: RW. A store writes write_data[26:0]. A load returns the value zero-extended.
- Offset 0x08, SW: RO. A load returns the debounced switches, zero-extended. Stores are ignored.
- Offset 0x10, CHG: sticky per-switch change flags. A store clears the flags where write_data[17:0] has a 1 (write-1-to-clear). A load returns the flags with no side effect.
- Offset 0x18, CNT: RO cycle counter, present only when configured (see Configuration). Stores are ignored.
- hit = in-window AND mapped offset. read_data = selected value when hit and MemRead; otherwise 0.
- Synchronizer: two flops, sync1 <= switches, sync2 <= sync1.
- Debounce, one counter per switch:
  - If sync2[i] == deb[i], cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1, then deb[i] <= sync2[i], cnt[i] <= 0, and chg[i] <= 1.
  - Else cnt[i] <= cnt[i]+1.
  - Counter width is $clog2(DEBOUNCE_CYCLES).
- A bounce that returns to the debounced value before the threshold restarts that switch's count; no flag is set.
- Simultaneous events:
  - W1C clear and a new change on the same switch in the same cycle: set wins, so chg[i] = 1.
  - MemRead and MemWrite both asserted: the store is performed and the load returns the pre-store value.
  - Store to an unmapped or RO offset: no state change; hit follows the decode rule.

## Timing
- Reset values:
  - leds = 0, sync1/sync2/deb/cnt/chg = 0, CNT = 0.
  - read_data = 0 and hit = 0 whenever MemRead is low or the address is out of window.
- Reset asserted mid-debounce clears all counts; no pending change survives.
- Load latency is 0 cycles: read_data is valid in the same cycle as MemRead, from state as it stood before the edge.
- Stores take effect at the rising edge where MemWrite is high. The new value is visible to a load in the next cycle.
- Switch-to-SW latency: for a raw change sampled at edge k that stays stable, deb updates at edge k+DEBOUNCE_CYCLES+1. chg is set at the same edge.
- CNT increments every cycle not in reset and wraps from 2^64-1 to 0. A load at cycle n after reset release returns n.

## Configuration
- IO_CYCLE_COUNTER_EN defined: the CNT register exists at offset 0x18.
- IO_CYCLE_COUNTER_EN undefined:
  - No counter hardware is present.
  - Offset 0x18 is unmapped: hit = 0, read_data = 0, and stores are ignored.

## Test plan
Benches use IO_BASE = 0x1000 and DEBOUNCE_CYCLES = 4 unless stated.
- Reset, then load 0x1000 -> read_data = 0, hit = 1, leds = 0.
- Store 0xFFFF_FFFF_FFFF_FFFF to 0x1000, then load 0x1000:
  - leds = 27'h7FFFFFF after the edge.
  - read_data = 64'h7FFFFFF.
  - A store to 0x1008 leaves SW unchanged.
- Switch 3 goes 0→1 at edge k and holds -> SW reads 0 through edge k+4 and reads 0x8 after edge k+5; CHG = 0x8.
- Switch 5 pulses high for 3 cycles -> SW and CHG stay 0. A following 5-cycle-stable high -> SW = 0x20, CHG = 0x20.
- CHG = 0x28, then store 0x8 to 0x1010 -> CHG = 0x20. A W1C of bit 5 in the same cycle a new switch-5 change is accepted -> bit 5 remains 1.
- Load 0x1018:
  - With IO_CYCLE_COUNTER_EN at cycle 10 after reset release -> read_data = 10, hit = 1.
  - Without it -> read_data = 0, hit = 0.
  - A load of 0x2000 -> hit = 0, read_data = 0.
